// File: rtl/mem_arbiter_2p.sv
// Two-port round-robin arbiter/sequencer for the 256x16 distributed RAM.
// Define MEM_WRPROT_EN to suppress port B writes to addresses <= WP_TOP.
module mem_arbiter_2p #(
  parameter int                ADDR_W = 8,
  parameter int                DATA_W = 16,
  parameter logic [ADDR_W-1:0] WP_TOP = 8'h7F
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

`ifdef MEM_WRPROT_EN
  localparam logic WP_ENABLE = 1'b1;
`else
  localparam logic WP_ENABLE = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state_reg;
  logic              last_grant_reg;   // 0 = A, 1 = B
  logic              grant_reg;        // port owning the current access
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              a_ack_reg;
  logic              b_ack_reg;
  logic              b_err_reg;

  logic                   grant_valid;
  logic                   pick_b;
  logic                   wp_hit;
  logic [1:0]             port_sel;
  logic [1:0][DATA_W-1:0] rdata_reg;
  logic [1:0][DATA_W-1:0] rdata_next;

  // B wins only when A is idle or A was the last port served.
  assign grant_valid = (a_req || b_req) && !halt;
  assign pick_b      = b_req && (!a_req || !last_grant_reg);

  assign wp_hit   = WP_ENABLE && grant_reg && we_reg && (addr_reg <= WP_TOP);
  assign port_sel = {grant_reg, !grant_reg};

  // Write strobe is decoded from state so an async reset kills it at once.
  assign mem_we    = (state_reg == ACCESS) && we_reg && !wp_hit;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign busy      = (state_reg != IDLE);

  assign a_ack   = a_ack_reg;
  assign b_ack   = b_ack_reg;
  assign b_err   = b_err_reg;
  assign a_rdata = rdata_reg[0];
  assign b_rdata = rdata_reg[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
      assign rdata_next[gi] = (state_reg == ACCESS && !we_reg && port_sel[gi])
                              ? mem_rdata : rdata_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      grant_reg      <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      a_ack_reg      <= 1'b0;
      b_ack_reg      <= 1'b0;
      b_err_reg      <= 1'b0;
      rdata_reg      <= '0;
    end else begin
      rdata_reg <= rdata_next;
      case (state_reg)
        IDLE: begin
          a_ack_reg <= 1'b0;
          b_ack_reg <= 1'b0;
          b_err_reg <= 1'b0;
          if (grant_valid) begin
            grant_reg      <= pick_b;
            last_grant_reg <= pick_b;
            we_reg         <= pick_b && b_we;
            addr_reg       <= pick_b ? b_addr : a_addr;
            if (pick_b) begin
              wdata_reg <= b_wdata;
            end
            state_reg <= ACCESS;
          end
        end
        ACCESS: begin
          a_ack_reg <= !grant_reg;
          b_ack_reg <= grant_reg;
          b_err_reg <= wp_hit;
          state_reg <= DONE;
        end
        DONE: begin
          a_ack_reg <= 1'b0;
          b_ack_reg <= 1'b0;
          b_err_reg <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Directed bench for mem_arbiter_2p with a negedge-write, async-read RAM model.
module tb_mem_arbiter_2p;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt;
  logic        a_req;
  logic [7:0]  a_addr;
  logic        a_ack;
  logic [15:0] a_rdata;
  logic        b_req;
  logic        b_we;
  logic [7:0]  b_addr;
  logic [15:0] b_wdata;
  logic        b_ack;
  logic [15:0] b_rdata;
  logic        b_err;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic        busy;

  logic [15:0] mem [0:255];
  logic        preload;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_2p dut (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // RAM model: word i preloads to {i,i}, except word 0 = 0x1234.
  always @(negedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 0) ? 16'h1234 : {i[7:0], i[7:0]};
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single port-B access with no competing request; leaves bench in IDLE.
  task automatic access_b(input logic we, input logic [7:0] addr, input logic [15:0] wdata,
                          input logic exp_we, input logic exp_err);
    b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
    tick();
    check("accb_mem_we", mem_we, exp_we);
    check("accb_mem_addr", mem_addr, addr);
    tick();
    check("accb_b_ack", b_ack, 1'b1);
    check("accb_b_err", b_err, exp_err);
    b_req = 1'b0; b_we = 1'b0;
    tick();
  endtask

  task automatic access_a(input logic [7:0] addr, input logic [15:0] exp_data);
    a_req = 1'b1; a_addr = addr;
    tick();
    check("acca_mem_we", mem_we, 1'b0);
    tick();
    check("acca_a_ack", a_ack, 1'b1);
    check("acca_a_rdata", a_rdata, exp_data);
    a_req = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; preload = 1'b1; halt = 1'b0;
    a_req = 1'b0; a_addr = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (3) tick();
    preload = 1'b0;
    check("rst_a_ack", a_ack, 1'b0);
    check("rst_b_ack", b_ack, 1'b0);
    check("rst_b_err", b_err, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_a_rdata", a_rdata, 16'h0);
    check("rst_b_rdata", b_rdata, 16'h0);
    check("rst_mem_addr", mem_addr, 8'h0);
    check("rst_mem_wdata", mem_wdata, 16'h0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Fairness: both read continuously; acks after ticks 2,5,8,11 as A,B,A,B.
    a_req = 1'b1; a_addr = 8'h20;
    b_req = 1'b1; b_addr = 8'h21; b_we = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k % 3 == 2) begin
        check("rr_a_ack", a_ack, (((k - 2) / 3) % 2 == 0) ? 1'b1 : 1'b0);
        check("rr_b_ack", b_ack, (((k - 2) / 3) % 2 == 1) ? 1'b1 : 1'b0);
        if (((k - 2) / 3) % 2 == 0) check("rr_a_rdata", a_rdata, 16'h2020);
        else                        check("rr_b_rdata", b_rdata, 16'h2121);
      end else begin
        check("rr_no_ack", {a_ack, b_ack}, 2'b00);
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    tick();
    check("rr_idle_busy", busy, 1'b0);

    // B writes 0xBEEF @0x90, A reads it back.
    b_req = 1'b1; b_we = 1'b1; b_addr = 8'h90; b_wdata = 16'hBEEF;
    tick();
    check("wr_mem_we", mem_we, 1'b1);
    check("wr_mem_addr", mem_addr, 8'h90);
    check("wr_mem_wdata", mem_wdata, 16'hBEEF);
    check("wr_b_ack_early", b_ack, 1'b0);
    check("wr_busy", busy, 1'b1);
    tick();
    check("wr_b_ack", b_ack, 1'b1);
    check("wr_b_err", b_err, 1'b0);
    check("wr_mem_we_done", mem_we, 1'b0);
    check("wr_ram", mem[8'h90], 16'hBEEF);
    b_req = 1'b0; b_we = 1'b0; a_req = 1'b1; a_addr = 8'h90;
    tick();
    check("wr_b_ack_gone", b_ack, 1'b0);
    check("wr_idle", busy, 1'b0);
    tick();
    check("rd_mem_we", mem_we, 1'b0);
    check("rd_mem_addr", mem_addr, 8'h90);
    tick();
    check("rd_a_ack", a_ack, 1'b1);
    check("rd_a_rdata", a_rdata, 16'hBEEF);
    a_req = 1'b0;
    tick();

    // B read of preloaded word 0; A's read data must be untouched.
    access_b(1'b0, 8'h00, 16'h0, 1'b0, 1'b0);
    check("b0_b_rdata", b_rdata, 16'h1234);
    check("b0_a_rdata", a_rdata, 16'hBEEF);

    // halt during A's access: ack still issued, B waits for halt release.
    a_req = 1'b1; a_addr = 8'h21;
    tick();
    halt = 1'b1; b_req = 1'b1; b_we = 1'b0; b_addr = 8'h20;
    tick();
    check("halt_a_ack", a_ack, 1'b1);
    check("halt_a_rdata", a_rdata, 16'h2121);
    a_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("halt_no_grant", busy, 1'b0);
    end
    halt = 1'b0;
    tick();
    check("unhalt_busy", busy, 1'b1);
    check("unhalt_mem_addr", mem_addr, 8'h20);
    tick();
    check("unhalt_b_ack", b_ack, 1'b1);
    check("unhalt_b_rdata", b_rdata, 16'h2020);
    b_req = 1'b0;
    tick();

    // Async reset in the middle of B's write access.
    b_req = 1'b1; b_we = 1'b1; b_addr = 8'h30; b_wdata = 16'h5A5A;
    tick();
    check("rstmid_mem_we_pre", mem_we, 1'b1);
    #1 rst_n = 1'b0;
    b_req = 1'b0; b_we = 1'b0;
    #1;
    check("rstmid_mem_we", mem_we, 1'b0);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_b_ack", b_ack, 1'b0);
    check("rstmid_mem_addr", mem_addr, 8'h00);
    tick();
    check("rstmid_ram", mem[8'h30], 16'h3030);
    check("rstmid_no_ack", b_ack, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    a_req = 1'b1; a_addr = 8'h21;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h20;
    tick();
    check("postrst_first_grant", mem_addr, 8'h21);
    tick();
    check("postrst_a_ack", a_ack, 1'b1);
    check("postrst_b_ack", b_ack, 1'b0);
    check("postrst_a_rdata", a_rdata, 16'h2121);
    a_req = 1'b0;
    tick();
    tick();
    tick();
    check("postrst_b_ack2", b_ack, 1'b1);
    check("postrst_b_rdata", b_rdata, 16'h2020);
    b_req = 1'b0;
    tick();

`ifdef MEM_WRPROT_EN
    access_b(1'b1, 8'h10, 16'h5555, 1'b0, 1'b1);
    check("wp_ram_kept", mem[8'h10], 16'h1010);
    check("wp_b_rdata_kept", b_rdata, 16'h2020);
    access_a(8'h10, 16'h1010);
    access_b(1'b1, 8'h80, 16'h5555, 1'b1, 1'b0);
    access_b(1'b0, 8'h80, 16'h0, 1'b0, 1'b0);
    check("wp_hi_rdata", b_rdata, 16'h5555);
`else
    access_b(1'b1, 8'h10, 16'h5555, 1'b1, 1'b0);
    check("nowp_ram", mem[8'h10], 16'h5555);
    access_a(8'h10, 16'h5555);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter_2p.md
Name: mem_arbiter_2p

Overview:
- Two-port access arbiter and sequencer in front of the 256x16 distributed-RAM memory (normal-mode port: address, data, write enable, read data).
- Shares the memory between port A (instruction fetch, read-only) and port B (load/store, read/write).
- Uses round-robin arbitration, a req/ack handshake and registered read data.
- Sits between the multicycle RISC datapath and the memory; test-mode muxing stays inside the memory.

Parameters:
- ADDR_W, 8, address width (memory depth 2^ADDR_W words).
- DATA_W, 16, data word width.
- WP_TOP, 8'h7F, highest write-protected address (used only with the optional feature).

Ports:
- clk  in  1  system clock; the memory's clk_n port is driven from this same net.
- rst_n  in  1  asynchronous active-low reset.
- halt  in  1  1 = grant no new accesses; an in-flight access still completes.
- a_req  in  1  port A request; held high until a_ack.
- a_addr  in  ADDR_W  port A read address.
- a_ack  out  1  one-cycle completion pulse for port A.
- a_rdata  out  DATA_W  port A read data, registered.
- b_req  in  1  port B request; held high until b_ack.
- b_we  in  1  port B: 1 = write, 0 = read.
- b_addr  in  ADDR_W  port B address.
- b_wdata  in  DATA_W  port B write data.
- b_ack  out  1  one-cycle completion pulse for port B.
- b_rdata  out  DATA_W  port B read data, registered.
- b_err  out  1  protected-write flag; valid with b_ack.
- mem_addr  out  ADDR_W  to memory Addr_pc.
- mem_wdata  out  DATA_W  to memory Data_pc.
- mem_we  out  1  to memory WE_pc.
- mem_rdata  in  DATA_W  from memory MemOut (asynchronous read).
- busy  out  1  1 whenever state is not IDLE.

Behaviour:
- Reset:
  - State goes to IDLE.
  - a_ack, b_ack, b_err and mem_we are 0. mem_we is forced 0 asynchronously.
  - a_rdata, b_rdata, mem_addr and mem_wdata are 0.
  - The last-grant register resets to B, so A wins the first contention.
- FSM: IDLE -> ACCESS -> DONE -> IDLE. Every access takes exactly 3 cycles.
- IDLE:
  - Requests are sampled only in this state, and only when halt = 0.
  - Arbitration:
    - If only one req is high, that port is granted.
    - If both are high, grant the port not granted last time, then update last-grant.
  - On a grant, latch the port id, address, write data and we (we = 0 for A). Go to ACCESS.
  - No req high, or halt = 1: stay in IDLE.
- ACCESS:
  - mem_addr and mem_wdata are driven from the latched registers.
  - mem_we = latched we, decoded combinationally from state.
  - The memory writes on the falling clk edge inside this cycle.
  - On the closing rising edge, mem_rdata is captured into the granted port's rdata, for reads only. A write leaves rdata unchanged.
  - Next state is DONE.
- DONE:
  - The granted port's ack is high for exactly this cycle; mem_we = 0.
  - Next state is IDLE.
  - A req still high in the following IDLE cycle is treated as a new request. This allows back-to-back access at one per 3 cycles.
- Outside ACCESS, mem_addr and mem_wdata hold their last value.
- halt rising during ACCESS or DONE does not abort the access; the ack is still issued.
- The requester must keep addr, data and we stable from req until ack. Changes after the IDLE grant edge are ignored.
- Asynchronous reset mid-access:
  - The access is abandoned and no ack is issued.
  - A write is either complete or not started; the write edge lies inside ACCESS, so the memory content at that address is undefined for that cycle only.
- Fairness: with both ports requesting continuously, grants alternate A, B, A, B…

Optional Feature:
- Macro: MEM_WRPROT_EN.
- Defined:
  - A port B write with latched addr <= WP_TOP is suppressed: mem_we stays 0 in ACCESS.
  - The access still completes normally with the same 3-cycle timing. b_ack pulses, b_rdata is unchanged, and b_err = 1 for the same cycle as b_ack.
  - Writes to addr > WP_TOP and all reads are unaffected, with b_err = 0.
- Undefined: no address check; b_err is tied to 0.

Test Plan:
- Reset, then port B writes 0xBEEF to address 0x90, then port A reads 0x90 -> mem_we high only in B's ACCESS cycle; b_ack at cycle 3; a_ack at cycle 6 with a_rdata = 0xBEEF.
- A and B both request reads in the same IDLE cycle, held continuously for 4 grants -> grant order A, B, A, B; each ack 3 cycles after its IDLE grant; never both acks high together.
- halt = 1 while A is in ACCESS -> a_ack still pulses in DONE; B requesting meanwhile gets no grant until halt = 0, then is granted on the next IDLE edge.
- rst_n asserted low mid-ACCESS of a B write -> mem_we drops immediately; no b_ack; busy = 0; after release, A wins the first contention.
- B read at 0x00 with a preloaded value of 0x1234 -> b_rdata = 0x1234 with b_ack; a_rdata unchanged.
- With MEM_WRPROT_EN: B writes 0x5555 to 0x10 -> mem_we stays 0, b_err = 1 with b_ack, a later read of 0x10 returns the old data. Writing 0x5555 to 0x80 succeeds with b_err = 0.
